// File: rtl/serial_transmitter_fifo.sv
// UART transmitter with configurable frame format and an input FIFO.
// Frames queued in the FIFO go out back-to-back with no idle gap between them.
module serial_transmitter_fifo #(
  parameter int ClockFrequency = 16000000,
  parameter int BaudRate       = 115200,
  parameter int DataBits       = 8,
  parameter int Parity         = 0,
  parameter int StopBits       = 1,
  parameter int FifoDepth      = 4
) (
  input  logic                           iClock,
  input  logic                           iResetN,
  input  logic [DataBits-1:0]            iData,
  input  logic                           iSend,
  output logic                           oReady,
  output logic                           oOverflow,
  output logic                           oBusy,
  output logic [$clog2(FifoDepth+1)-1:0] oFifoLevel,
  output logic                           oTXD
);

  // state   | meaning
  // sIdle   | line at mark, waiting for the FIFO to hold a word
  // sStart  | start bit (space)
  // sData   | data bits, LSB first
  // sParity | parity bit, value fixed when the word was loaded
  // sStop   | stop bits; the final tick may load the next word directly
  localparam int TicksPerBit = ClockFrequency / BaudRate;
  localparam int TickW       = $clog2(TicksPerBit);
  localparam int PtrW        = $clog2(FifoDepth);
  localparam int LvlW        = $clog2(FifoDepth + 1);
  localparam int IdxW        = $clog2(DataBits);

  if (TicksPerBit < 3) begin : g_bad_ticks
    $error("serial_transmitter_fifo: ClockFrequency/BaudRate must be >= 3");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_data_bits
    $error("serial_transmitter_fifo: DataBits must be 5..9");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_parity
    $error("serial_transmitter_fifo: Parity must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop_bits
    $error("serial_transmitter_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("serial_transmitter_fifo: FifoDepth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {sIdle, sStart, sData, sParity, sStop} state_t;

  state_t               state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic                 bit_end_q, bit_end_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DataBits-1:0]  shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 txd_q, txd_d;
  logic [DataBits-1:0]  fifo_mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 ready_q, ready_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic                 push, pop;
  logic [DataBits-1:0]  head;

  assign push = iSend && ready_q;
  assign head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pop       = 1'b0;
    tick_d    = (state_q == sIdle || bit_end_q) ? '0 : tick_q + TickW'(1);
    // Compare one tick ahead so bit_end_q is a flop, not a decode of tick_q.
    bit_end_d = (state_q != sIdle) && (tick_q == TickW'(TicksPerBit - 2));

    case (state_q)
      sIdle: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = sStart;
        end
      end
      sStart: begin
        if (bit_end_q) begin
          state_d   = sData;
          bit_idx_d = '0;
        end
      end
      sData: begin
        if (bit_end_q) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == IdxW'(DataBits - 1)) begin
            bit_idx_d = '0;
            state_d   = (Parity != 0) ? sParity : sStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      sParity: begin
        if (bit_end_q) state_d = sStop;
      end
      sStop: begin
        if (bit_end_q) begin
          if (bit_idx_q == IdxW'(StopBits - 1)) begin
            bit_idx_d = '0;
            if (level_q != '0) begin
              pop     = 1'b1;
              state_d = sStart;
            end else begin
              state_d = sIdle;
            end
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = sIdle;
    endcase

    if (pop) begin
      shift_d  = head;
      parity_d = (^head) ^ (Parity == 2);
    end

    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    ready_d    = (level_d != LvlW'(FifoDepth));
    overflow_d = iSend && !ready_q;
    busy_d     = (state_d != sIdle) || (level_d != '0);

    case (state_q)
      sStart:  txd_d = 1'b0;
      sData:   txd_d = shift_q[0];
      sParity: txd_d = parity_q;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      state_q    <= sIdle;
      tick_q     <= '0;
      bit_end_q  <= 1'b0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_end_q  <= bit_end_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge iClock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= iData;
  end

  assign oReady     = ready_q;
  assign oOverflow  = overflow_q;
  assign oBusy      = busy_q;
  assign oFifoLevel = level_q;
  assign oTXD       = txd_q;

endmodule

// File: tb/tb_serial_transmitter_fifo.sv
// Scoreboard bench: three transmitter configurations (8N1, 7E2, 8O1) at 8 ticks per bit.
// Stimulus queues expected frames; per-line monitors check every cycle of each frame.
module tb_serial_transmitter_fifo;

  localparam int Tpb = 8;

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          nbits;
    int          gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic       send  [3];
  logic [7:0] din   [3];
  logic       ready [3];
  logic       ovf   [3];
  logic       busy  [3];
  logic [2:0] lvl   [3];
  logic       txd   [3];

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  frame_t exp_q[$];

  int lvl_e[6] = '{1, 1, 2, 3, 4, 4};
  int rdy_e[6] = '{1, 1, 1, 1, 0, 0};
  int ovf_e[6] = '{0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_transmitter_fifo #(
    .ClockFrequency(16000000), .BaudRate(2000000), .DataBits(8),
    .Parity(0), .StopBits(1), .FifoDepth(4)
  ) u_8n1 (
    .iClock(clk), .iResetN(rst_n[0]), .iData(din[0]), .iSend(send[0]),
    .oReady(ready[0]), .oOverflow(ovf[0]), .oBusy(busy[0]),
    .oFifoLevel(lvl[0]), .oTXD(txd[0])
  );

  serial_transmitter_fifo #(
    .ClockFrequency(16000000), .BaudRate(2000000), .DataBits(7),
    .Parity(1), .StopBits(2), .FifoDepth(4)
  ) u_7e2 (
    .iClock(clk), .iResetN(rst_n[1]), .iData(din[1][6:0]), .iSend(send[1]),
    .oReady(ready[1]), .oOverflow(ovf[1]), .oBusy(busy[1]),
    .oFifoLevel(lvl[1]), .oTXD(txd[1])
  );

  serial_transmitter_fifo #(
    .ClockFrequency(16000000), .BaudRate(2000000), .DataBits(8),
    .Parity(2), .StopBits(1), .FifoDepth(4)
  ) u_8o1 (
    .iClock(clk), .iResetN(rst_n[2]), .iData(din[2]), .iSend(send[2]),
    .oReady(ready[2]), .oOverflow(ovf[2]), .oBusy(busy[2]),
    .oFifoLevel(lvl[2]), .oTXD(txd[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_frame(input int k, input logic [15:0] b, input int n, input int g);
    frame_t f;
    f.inst  = k;
    f.bits  = b;
    f.nbits = n;
    f.gap   = g;
    exp_q.push_back(f);
  endtask

  task automatic wait_not_busy(input int k, output int drop_cyc, output int ready_lows);
    int n;
    n = 0;
    ready_lows = 0;
    while (busy[k] && n < 2000) begin
      if (!ready[k]) ready_lows++;
      @(negedge clk);
      n++;
    end
    chk("busy_drop_bound", int'(busy[k]), 0);
    drop_cyc = cyc;
  endtask

  // Samples the line 1 time unit after each rising edge.
  task automatic monitor(input int k);
    int          idle;
    frame_t      f;
    logic        bad;
    logic        aborted;
    logic [15:0] got;
    idle = 1000;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n[k]) begin
        idle = 1000;
      end else if (txd[k] === 1'b1) begin
        if (idle < 1000) idle++;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: line %0d started a frame, expected none (cycle %0d)", k, cyc);
        for (int w = 0; w < 20 && txd[k] !== 1'b1; w++) begin
          @(posedge clk);
          #1;
        end
        idle = 0;
      end else begin
        f = exp_q.pop_front();
        chk("frame_line", k, f.inst);
        if (f.gap >= 0) chk("frame_gap", idle, f.gap);
        bad     = 1'b0;
        aborted = 1'b0;
        got     = '0;
        for (int c = 0; c < f.nbits * Tpb; c++) begin
          if (c > 0) begin
            @(posedge clk);
            #1;
          end
          if (!rst_n[k]) begin
            aborted = 1'b1;
            break;
          end
          if (c % Tpb == Tpb / 2) got[c / Tpb] = txd[k];
          if (txd[k] !== f.bits[c / Tpb]) bad = 1'b1;
        end
        if (!aborted) begin
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL frame_bits line %0d: got %h expected %h (cycle %0d)", k, got, f.bits, cyc);
          end
        end
        idle = aborted ? 1000 : 0;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, drop, lows, tx_lows;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      send[k]  = 1'b0;
      din[k]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_txd", int'(txd[k]), 1);
      chk("reset_ready", int'(ready[k]), 0);
      chk("reset_busy", int'(busy[k]), 0);
      chk("reset_level", int'(lvl[k]), 0);
      chk("reset_overflow", int'(ovf[k]), 0);
      rst_n[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ready_after_reset", int'(ready[k]), 1);

    // 8N1, 0x55 while idle
    add_frame(0, 16'h02AA, 10, -1);
    send[0] = 1'b1;
    din[0]  = 8'h55;
    @(negedge clk);
    send[0] = 1'b0;
    acc = cyc;
    chk("s1_level_after_push", int'(lvl[0]), 1);
    chk("s1_busy_after_push", int'(busy[0]), 1);
    chk("s1_ready_after_push", int'(ready[0]), 1);
    chk("s1_txd_at_accept", int'(txd[0]), 1);
    @(negedge clk);
    chk("s1_txd_accept_plus1", int'(txd[0]), 1);
    chk("s1_level_after_pop", int'(lvl[0]), 0);
    @(negedge clk);
    chk("s1_txd_falls_accept_plus2", int'(txd[0]), 0);
    wait_not_busy(0, drop, lows);
    // busy falls 80 edges after the edge that entered sStart (acceptance + 1)
    chk("s1_busy_length", drop - (acc + 1), 80);
    chk("s1_ready_stays_high", lows, 0);
    repeat (4) @(negedge clk);

    // 7E2, 0x41
    add_frame(1, 16'h0682, 11, -1);
    send[1] = 1'b1;
    din[1]  = 8'h41;
    @(negedge clk);
    send[1] = 1'b0;
    acc = cyc;
    wait_not_busy(1, drop, lows);
    chk("s2_frame_length", drop - (acc + 1), 88);
    repeat (4) @(negedge clk);

    // 8O1, 0x03 then 0x07 back-to-back
    add_frame(2, 16'h0606, 11, -1);
    add_frame(2, 16'h040E, 11, 0);
    send[2] = 1'b1;
    din[2]  = 8'h03;
    @(negedge clk);
    din[2]  = 8'h07;
    @(negedge clk);
    send[2] = 1'b0;
    wait_not_busy(2, drop, lows);
    repeat (4) @(negedge clk);

    // 8N1 FIFO fill: six pushes, the sixth dropped
    add_frame(0, 16'h0220, 10, -1);
    add_frame(0, 16'h0222, 10, 0);
    add_frame(0, 16'h0224, 10, 0);
    add_frame(0, 16'h0226, 10, 0);
    add_frame(0, 16'h0228, 10, 0);
    for (int i = 0; i < 6; i++) begin
      send[0] = 1'b1;
      din[0]  = 8'h10 + 8'(i);
      @(negedge clk);
      chk("fill_level", int'(lvl[0]), lvl_e[i]);
      chk("fill_ready", int'(ready[0]), rdy_e[i]);
      chk("fill_overflow", int'(ovf[0]), ovf_e[i]);
    end
    send[0] = 1'b0;
    @(negedge clk);
    chk("fill_overflow_single_pulse", int'(ovf[0]), 0);
    chk("fill_level_held", int'(lvl[0]), 4);
    wait_not_busy(0, drop, lows);
    repeat (4) @(negedge clk);

    // Push coinciding with the sStop->sStart pop
    add_frame(0, 16'h0278, 10, -1);
    add_frame(0, 16'h02B4, 10, 0);
    add_frame(0, 16'h0386, 10, 0);
    send[0] = 1'b1;
    din[0]  = 8'h3C;
    @(negedge clk);
    din[0]  = 8'h5A;
    @(negedge clk);
    send[0] = 1'b0;
    chk("pp_level_first_overlap", int'(lvl[0]), 1);
    repeat (79) @(negedge clk);
    chk("pp_level_before", int'(lvl[0]), 1);
    send[0] = 1'b1;
    din[0]  = 8'hC3;
    @(negedge clk);
    send[0] = 1'b0;
    chk("pp_level_push_pop", int'(lvl[0]), 1);
    chk("pp_txd_still_stop", int'(txd[0]), 1);
    wait_not_busy(0, drop, lows);
    repeat (4) @(negedge clk);

    // Reset during data bit 3 of 0xA5 with two words queued
    add_frame(0, 16'h034A, 10, -1);
    send[0] = 1'b1;
    din[0]  = 8'hA5;
    @(negedge clk);
    din[0]  = 8'h11;
    @(negedge clk);
    din[0]  = 8'h22;
    @(negedge clk);
    send[0] = 1'b0;
    chk("rst_level_queued", int'(lvl[0]), 2);
    repeat (33) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_txd", int'(txd[0]), 1);
    chk("rst_mid_level", int'(lvl[0]), 0);
    chk("rst_mid_ready", int'(ready[0]), 0);
    chk("rst_mid_busy", int'(busy[0]), 0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", int'(ready[0]), 1);
    tx_lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) tx_lows++;
    end
    chk("rst_no_further_frames", tx_lows, 0);
    chk("rst_busy_quiet", int'(busy[0]), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_transmitter_fifo.md
Name: serial_transmitter_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds configurable data width, parity and stop bits, plus an input FIFO so a producer can queue several bytes ahead of the line. Sits between on-chip logic and the TXD pin. Consecutive frames are sent back-to-back with no idle gap while the FIFO holds data.

Parameters:
ClockFrequency, 16000000, top-level clock frequency in Hz
BaudRate, 115200, line rate; TicksPerBit = ClockFrequency / BaudRate (integer division), must be >= 3
DataBits, 8, data bits per frame, legal 5..9
Parity, 0, 0 = none, 1 = even, 2 = odd
StopBits, 1, legal 1 or 2
FifoDepth, 4, FIFO entries, power of two, >= 2
Illegal parameter values stop elaboration with a $error message.

Ports:
iClock  in  1  top-level clock at ClockFrequency
iResetN  in  1  synchronous reset, active low
iData  in  DataBits  word to queue, sampled only on a cycle where iSend && oReady
iSend  in  1  push request; each sampled cycle pushes one word
oReady  out  1  FIFO not full; a push is accepted this cycle
oOverflow  out  1  one-cycle pulse when iSend is asserted while oReady=0 (word dropped)
oBusy  out  1  frame in progress or FIFO non-empty
oFifoLevel  out  $clog2(FifoDepth+1)  current FIFO occupancy
oTXD  out  1  UART serial output, idle high

Behaviour:
- Reset (iResetN=0 at a rising edge):
  - FIFO flushed; FSM to sIdle; bit timer and bit index cleared.
  - oTXD=1, oReady=0, oOverflow=0, oBusy=0, oFifoLevel=0.
  - The first edge with iResetN=1 sets oReady=1.
  - Reset mid-frame aborts the frame; the line returns to mark at the reset edge.
- FIFO:
  - Push when iSend && oReady. Pop when the FSM loads a frame.
  - Push and pop in the same cycle leaves the level unchanged.
  - Pointers wrap modulo FifoDepth.
  - oReady and oFifoLevel are registered and reflect the level after that edge.
  - A push is never accepted while full; the word is dropped and oOverflow pulses.
- FSM states: sIdle, sStart, sData, sParity, sStop.
  - sIdle: if the FIFO is non-empty, pop into the shift register and go to sStart.
  - sStart: lasts TicksPerBit cycles, then sData.
  - sData: DataBits bits, LSB first, each TicksPerBit cycles. After the last bit, go to sParity if Parity != 0, else sStop.
  - sParity: one bit time. Bit value = XOR of the data bits for even parity, inverted for odd. The value is computed at load time.
  - sStop: StopBits bit times.
    - On the final tick, if the FIFO is non-empty, pop and go directly to sStart (no gap).
    - Otherwise go to sIdle.
- Bit timer:
  - Counts 0..TicksPerBit-1 and resets on each bit boundary.
  - The end-of-bit compare is registered one cycle early.
  - Every bit is exactly TicksPerBit cycles.
- oTXD:
  - Registered from state and the shift register LSB, so it lags the FSM by one cycle.
  - Levels: sIdle and sStop = 1, sStart = 0, sData = current bit, sParity = parity bit.
- Latency: iSend accepted at edge N with the FSM idle and the FIFO empty → sStart at edge N+1 → oTXD falls at edge N+2.
- oBusy = (state != sIdle) || (level != 0), registered.
- Frame length in cycles = TicksPerBit × (1 + DataBits + (Parity != 0) + StopBits).

Test Plan:
- Bench setup for all scenarios: ClockFrequency=16000000, BaudRate=2000000 (TicksPerBit=8).
- 8N1, push 0x55 while idle → oTXD falls 2 cycles after acceptance; line reads 0,1,0,1,0,1,0,1,0,1 with 8 cycles per bit; oBusy drops after 80 cycles; oReady stays 1.
- DataBits=7, Parity=1, StopBits=2, push 0x41 → bits 0,1,0,0,0,0,0,1,0(parity),1,1; frame length 88 cycles.
- Parity=2, push 0x03 → parity bit 1; push 0x07 → parity bit 0.
- FifoDepth=4, iSend held for 6 consecutive cycles with values 0x10..0x15 while idle:
  - 0x10..0x14 are accepted; oFifoLevel reaches 4 and oReady goes 0.
  - 0x15 is dropped with a single oOverflow pulse.
  - Five frames follow with no idle cycles between the last stop bit and the next start bit.
- Reset asserted for 1 cycle during data bit 3 of 0xA5 with 2 bytes queued → oTXD=1 at the reset edge, oFifoLevel=0, oReady=0 then 1 the next cycle; no further frames are sent.
- Push with push+pop coincident: FIFO at level 1, push accepted on the same edge as the sStop→sStart pop → oFifoLevel stays 1 and byte order is preserved.
